// File: rtl/reg_file_p.sv
// Register file with a small op decoder, ALU write-back port, two async read ports and a jump/branch request.
// One op per cycle, committed on the next rising edge; no stalls; synchronous active-high reset.
module reg_file_p #(
  parameter int DW   = 8,
  parameter int NREG = 16,
  localparam int AW  = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [4:0]      op,
  input  logic [AW-1:0]   rd,
  input  logic [AW-1:0]   rs,
  input  logic [DW/2-1:0] imm,
  input  logic [1:0]      func,
  input  logic            alu_we,
  input  logic [AW-1:0]   alu_wa,
  input  logic [DW-1:0]   alu_wd,
  input  logic [AW-1:0]   ra,
  input  logic [AW-1:0]   rb,
  output logic [DW-1:0]   qa,
  output logic [DW-1:0]   qb,
  output logic            take,
  output logic            rel,
  output logic [DW-1:0]   target,
  output logic            carry,
  output logic            done
);

  localparam logic [4:0] OP_LIT_LO = 5'd4;
  localparam logic [4:0] OP_LIT_HI = 5'd5;
  localparam logic [4:0] OP_MOV    = 5'd6;
  localparam logic [4:0] OP_INCR   = 5'd10;
  localparam logic [4:0] OP_DECR   = 5'd11;
  localparam logic [4:0] OP_JIZR   = 5'd12;
  localparam logic [4:0] OP_JNZR   = 5'd13;
  localparam logic [4:0] OP_BIZR   = 5'd14;
  localparam logic [4:0] OP_BNZR   = 5'd15;
  localparam logic [4:0] OP_SETH   = 5'd17;
  localparam logic [4:0] OP_LSLC   = 5'd20;
  localparam logic [4:0] OP_LSRC   = 5'd21;
  localparam logic [4:0] OP_FLIP   = 5'd22;
  localparam logic [4:0] OP_FUNC   = 5'd23;
  localparam logic [1:0] FN_DONE   = 2'd3;

  logic [DW-1:0] r_regs [NREG];
  logic          r_take;
  logic          r_rel;
  logic [DW-1:0] r_target;
  logic          r_carry;
  logic          r_done;

  logic [DW-1:0] w_rd_val;
  logic [DW-1:0] w_rs_val;
  logic          w_rd_zero;
  logic          w_op_we;
  logic [DW-1:0] w_op_wd;
  logic          w_carry_nxt;
  logic          w_jump;
  logic          w_rel_nxt;
  logic          w_done_set;

  // Sources and conditions always come from pre-edge contents.
  assign w_rd_val  = r_regs[rd];
  assign w_rs_val  = r_regs[rs];
  assign w_rd_zero = (w_rd_val == '0);

  always_comb begin
    w_op_we     = 1'b0;
    w_op_wd     = w_rd_val;
    w_carry_nxt = r_carry;
    w_jump      = 1'b0;
    w_rel_nxt   = 1'b0;
    w_done_set  = 1'b0;
    case (op)
      OP_LIT_LO: begin w_op_we = 1'b1; w_op_wd = {w_rd_val[DW-1:DW/2], imm}; end
      OP_LIT_HI: begin w_op_we = 1'b1; w_op_wd = {imm, w_rd_val[DW/2-1:0]}; end
      OP_MOV:    begin w_op_we = 1'b1; w_op_wd = w_rs_val; end
      OP_INCR:   begin w_op_we = 1'b1; w_op_wd = w_rd_val + DW'(1); end
      OP_DECR:   begin w_op_we = 1'b1; w_op_wd = w_rd_val - DW'(1); end
      OP_JIZR:   w_jump = w_rd_zero;
      OP_JNZR:   w_jump = !w_rd_zero;
      OP_BIZR:   begin w_jump = w_rd_zero;  w_rel_nxt = 1'b1; end
      OP_BNZR:   begin w_jump = !w_rd_zero; w_rel_nxt = 1'b1; end
      OP_SETH:   begin w_op_we = 1'b1; w_op_wd = {1'b1, w_rd_val[DW-2:0]}; end
      OP_LSLC: begin
        w_op_we     = 1'b1;
        w_op_wd     = {w_rd_val[DW-2:0], r_carry};
        w_carry_nxt = w_rd_val[DW-1];
      end
      OP_LSRC: begin
        w_op_we     = 1'b1;
        w_op_wd     = {r_carry, w_rd_val[DW-1:1]};
        w_carry_nxt = w_rd_val[0];
      end
      OP_FLIP:   begin w_op_we = 1'b1; w_op_wd = ~w_rd_val; end
      OP_FUNC:   w_done_set = (func == FN_DONE);
      default:   ;
    endcase
  end

  // The op write is issued after the ALU write so it wins on an address clash.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
      r_take   <= 1'b0;
      r_rel    <= 1'b0;
      r_target <= '0;
      r_carry  <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      if (alu_we)  r_regs[alu_wa] <= alu_wd;
      if (w_op_we) r_regs[rd]     <= w_op_wd;
      r_carry <= w_carry_nxt;
      r_take  <= w_jump;
      if (w_jump) begin
        r_rel    <= w_rel_nxt;
        r_target <= w_rs_val;
      end
      if (w_done_set) r_done <= 1'b1;
    end
  end

  assign qa     = r_regs[ra];
  assign qb     = r_regs[rb];
  assign take   = r_take;
  assign rel    = r_rel;
  assign target = r_target;
  assign carry  = r_carry;
  assign done   = r_done;

endmodule

// File: tb/tb_reg_file_p.sv
// Scoreboarded random + directed bench for reg_file_p against an arithmetic reference model.
module tb_reg_file_p;
  localparam int DW   = 8;
  localparam int NREG = 16;
  localparam int AW   = 4;
  localparam int M    = 1 << DW;
  localparam int H    = 1 << (DW / 2);

  logic            clk = 1'b0;
  logic            reset;
  logic [4:0]      op;
  logic [AW-1:0]   rd, rs, alu_wa, ra, rb;
  logic [DW/2-1:0] imm;
  logic [1:0]      func;
  logic            alu_we;
  logic [DW-1:0]   alu_wd;
  logic [DW-1:0]   qa, qb, target;
  logic            take, rel, carry, done;

  reg_file_p #(.DW(DW), .NREG(NREG)) dut (
    .clk(clk), .reset(reset), .op(op), .rd(rd), .rs(rs), .imm(imm), .func(func),
    .alu_we(alu_we), .alu_wa(alu_wa), .alu_wd(alu_wd), .ra(ra), .rb(rb),
    .qa(qa), .qb(qb), .take(take), .rel(rel), .target(target), .carry(carry), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int qa, qb, target;
    int take, rel, carry, done;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_err = 0;

  int m_r [NREG];
  int m_take, m_rel, m_target, m_carry, m_done;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_vec++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp_v, $time);
    end
  endtask

  // Monitor: outputs at each falling edge reflect the state after the previous rising edge.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("qa",     32'(qa),     32'(e.qa));
      chk("qb",     32'(qb),     32'(e.qb));
      chk("take",   32'(take),   32'(e.take));
      chk("rel",    32'(rel),    32'(e.rel));
      chk("target", 32'(target), 32'(e.target));
      chk("carry",  32'(carry),  32'(e.carry));
      chk("done",   32'(done),   32'(e.done));
    end
  end

  task automatic apply(input int o, input int rd_i, input int rs_i, input int imm_i,
                       input int fn, input int we, input int wa, input int wd,
                       input int ra_i, input int rb_i, input int rst);
    exp_t e;
    int   old [NREG];
    int   v, s, nv, wr, cond;
    @(posedge clk); #1;
    reset = rst[0]; op = o[4:0]; rd = rd_i[AW-1:0]; rs = rs_i[AW-1:0];
    imm = imm_i[DW/2-1:0]; func = fn[1:0]; alu_we = we[0]; alu_wa = wa[AW-1:0];
    alu_wd = wd[DW-1:0]; ra = ra_i[AW-1:0]; rb = rb_i[AW-1:0];
    e.qa = m_r[ra_i]; e.qb = m_r[rb_i];
    e.take = m_take; e.rel = m_rel; e.target = m_target; e.carry = m_carry; e.done = m_done;
    q.push_back(e);
    if (rst != 0) begin
      foreach (m_r[i]) m_r[i] = 0;
      m_take = 0; m_rel = 0; m_target = 0; m_carry = 0; m_done = 0;
      return;
    end
    old = m_r;
    v = old[rd_i]; s = old[rs_i]; nv = v; wr = 1; cond = -1;
    case (o)
      4:  nv = (v / H) * H + imm_i;
      5:  nv = imm_i * H + (v % H);
      6:  nv = s;
      10: nv = (v + 1) % M;
      11: nv = (v + M - 1) % M;
      17: nv = (v % (M / 2)) + M / 2;
      20: begin nv = (v * 2 + m_carry) % M; m_carry = v / (M / 2); end
      21: begin nv = v / 2 + m_carry * (M / 2); m_carry = v % 2; end
      22: nv = M - 1 - v;
      12, 14: begin wr = 0; cond = (v == 0); end
      13, 15: begin wr = 0; cond = (v != 0); end
      23: begin wr = 0; if (fn == 3) m_done = 1; end
      default: wr = 0;
    endcase
    m_take = (cond == 1);
    if (cond == 1) begin
      m_rel    = (o == 14 || o == 15);
      m_target = s;
    end
    if (we != 0) m_r[wa] = wd;
    if (wr != 0) m_r[rd_i] = nv;
  endtask

  task automatic nop(input int ra_i, input int rb_i);
    apply(0, 0, 0, 0, 0, 0, 0, 0, ra_i, rb_i, 0);
  endtask

  initial begin
    int o, bound;
    reset = 1'b1; op = '0; rd = '0; rs = '0; imm = '0; func = '0;
    alu_we = 1'b0; alu_wa = '0; alu_wd = '0; ra = '0; rb = '0;
    foreach (m_r[i]) m_r[i] = 0;
    m_take = 0; m_rel = 0; m_target = 0; m_carry = 0; m_done = 0;
    repeat (2) @(posedge clk);
    apply(0, 0, 0, 0, 0, 0, 0, 0, 3, 9, 1);

    apply(4, 3, 0, 4'hA, 0, 0, 0, 0, 3, 0, 0);
    apply(5, 3, 0, 4'h5, 0, 0, 0, 0, 3, 0, 0);
    nop(3, 3);

    apply(4, 2, 0, 4'hF, 0, 0, 0, 0, 2, 0, 0);
    apply(5, 2, 0, 4'hF, 0, 0, 0, 0, 2, 0, 0);
    apply(10, 2, 0, 0, 0, 0, 0, 0, 2, 0, 0);
    apply(11, 2, 0, 0, 0, 0, 0, 0, 2, 0, 0);
    nop(2, 1);

    apply(5, 4, 0, 4'h2, 0, 0, 0, 0, 4, 1, 0);
    apply(12, 1, 4, 0, 0, 0, 0, 0, 4, 1, 0);
    apply(13, 1, 4, 0, 0, 0, 0, 0, 4, 1, 0);
    apply(14, 4, 1, 0, 0, 0, 0, 0, 4, 1, 0);
    apply(15, 4, 4, 0, 0, 0, 0, 0, 4, 1, 0);
    nop(4, 1);

    apply(4, 5, 0, 4'h1, 0, 0, 0, 0, 5, 0, 0);
    apply(5, 5, 0, 4'h8, 0, 0, 0, 0, 5, 0, 0);
    apply(20, 5, 0, 0, 0, 0, 0, 0, 5, 0, 0);
    apply(21, 5, 0, 0, 0, 0, 0, 0, 5, 0, 0);
    nop(5, 5);

    apply(5, 6, 0, 4'h1, 0, 0, 0, 0, 6, 7, 0);
    apply(10, 6, 0, 0, 0, 1, 6, 8'h33, 6, 7, 0);
    apply(4, 6, 0, 4'h0, 0, 0, 0, 0, 6, 7, 0);
    apply(10, 6, 0, 0, 0, 1, 7, 8'h33, 6, 7, 0);
    apply(13, 7, 6, 0, 0, 1, 6, 8'h00, 6, 7, 0);
    nop(6, 7);

    apply(23, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    apply(23, 0, 0, 0, 3, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) nop(i, 15 - i);
    apply(0, 0, 0, 0, 0, 0, 0, 0, 6, 7, 1);
    nop(6, 7);

    apply(5, 4, 0, 4'h3, 0, 0, 0, 0, 4, 1, 0);
    apply(12, 1, 4, 0, 0, 1, 9, 8'h44, 4, 9, 1);
    nop(4, 9);
    nop(1, 9);

    for (int i = 0; i < 600; i++) begin
      o = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31))
                                       : int'($urandom_range(4, 23));
      apply(o, $urandom_range(0, NREG - 1), $urandom_range(0, NREG - 1),
            $urandom_range(0, H - 1), $urandom_range(0, 3), $urandom_range(0, 1),
            $urandom_range(0, NREG - 1), $urandom_range(0, M - 1),
            $urandom_range(0, NREG - 1), $urandom_range(0, NREG - 1),
            ($urandom_range(0, 59) == 0) ? 1 : 0);
    end
    nop(0, 1);

    bound = 0;
    while (q.size() != 0 && bound < 20) begin
      @(negedge clk); #1;
      bound++;
    end
    n_vec++;
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/reg_file_p.md
REG_FILE_P -- requirements
Module: reg_file_p

Interface
Parameters (name, default, meaning):
REQ-001 SHALL provide DW, 8: register data width; legal range 4-16, even values only.
REQ-002 SHALL provide NREG, 16: number of registers; power of two, minimum 4.
REQ-003 SHALL derive AW = log2(NREG) as a localparam.
Ports (name, direction, width, meaning):
REQ-004 SHALL provide clk, in, 1, single clock; all state updates on rising edge.
REQ-005 SHALL provide reset, in, 1, synchronous active-high reset.
REQ-006 SHALL provide op, in, 5, reg_OP code; values not listed in REQ-015 are no-ops.
REQ-007 SHALL provide rd, in, AW, destination/tested register; rs, in, AW, source register.
REQ-008 SHALL provide imm, in, DW/2, literal half-word for lit_lo/lit_hi.
REQ-009 SHALL provide func, in, 2, functions code (strl=0, strh=1, ndne=2, done=3).
REQ-010 SHALL provide alu_we, in, 1; alu_wa, in, AW; alu_wd, in, DW: ALU write-back port.
REQ-011 SHALL provide ra, in, AW; rb, in, AW; qa, out, DW; qb, out, DW: two asynchronous read ports.
REQ-012 SHALL provide take, out, 1; rel, out, 1; target, out, DW: registered control-transfer request.
REQ-013 SHALL provide carry, out, 1, shift carry flag; done, out, 1, sticky program-done flag.

Function
REQ-014 SHALL execute each op in one cycle, with the update visible on the edge after op is presented; no stalls, and a new op is accepted every cycle.
REQ-015 SHALL decode op as follows (R = register array; all arithmetic mod 2^DW):
- 4 lit_lo: R[rd][DW/2-1:0] <= imm; upper half unchanged.
- 5 lit_hi: R[rd][DW-1:DW/2] <= imm; lower half unchanged.
- 6 movEn: R[rd] <= R[rs].
- 10 incrEn: R[rd] <= R[rd]+1; all-ones wraps to 0.
- 11 decrEn: R[rd] <= R[rd]-1; 0 wraps to all-ones.
- 12 jizrEn / 13 jnzrEn: absolute jump to R[rs] if R[rd]==0 / !=0.
- 14 bizrEn / 15 bnzrEn: relative branch by R[rs] if R[rd]==0 / !=0.
- 17 sethEn: R[rd][DW-1] <= 1.
- 20 lslcEn: R[rd] <= {R[rd][DW-2:0], carry}; carry <= old R[rd][DW-1].
- 21 lsrcEn: R[rd] <= {carry, R[rd][DW-1:1]}; carry <= old R[rd][0].
- 22 flipEn: R[rd] <= ~R[rd].
- 23 funcEn: func==done sets done; done stays 1 until reset; other func codes leave done unchanged.
REQ-016 SHALL drive take=1 for exactly the one cycle after a jump/branch op whose condition holds, with rel=1 for codes 14/15, rel=0 for codes 12/13, and target = R[rs] sampled when the op was presented.
REQ-017 SHALL drive take=0 after an untaken or non-jump op; target and rel SHALL hold their previous values whenever take=0.
REQ-018 SHALL commit alu_we writes R[alu_wa] <= alu_wd on the same edge as the op.
REQ-019 SHALL give the op write priority on simultaneous op and ALU writes to the same register; writes to different registers both commit.
REQ-020 SHALL bypass the read ports: when the read address matches a write being committed this cycle, qa/qb return the old value; the written value appears after the edge, with no forwarding.
REQ-021 SHALL evaluate jump conditions and op sources on pre-edge register contents, including when an ALU write targets rd or rs in the same cycle.
REQ-022 SHALL ignore rd, rs, imm and func for ops that do not use them.

Reset
REQ-023 SHALL, while reset=1 at a clock edge, clear all R to 0 and set take=0, rel=0, target=0, carry=0 and done=0; ops and ALU writes in that cycle are discarded.
REQ-024 SHALL discard an op that is presented with reset asserted mid-stream; no take pulse SHALL follow it.

Verification
REQ-025 lit_lo rd=3 imm=0xA, then lit_hi rd=3 imm=0x5 (DW=8) -> R3=0x0A, then R3=0x5A; qa with ra=3 reads 0x5A.
REQ-026 R2=0xFF, incrEn rd=2 -> R2=0x00; decrEn rd=2 -> R2=0xFF.
REQ-027 R1=0, R4=0x20, jizrEn rd=1 rs=4 -> take=1, rel=0, target=0x20 for one cycle; jnzrEn with the same registers -> take=0.
REQ-028 carry=0, R5=0x81, lslcEn rd=5 -> R5=0x02, carry=1; then lsrcEn rd=5 -> R5=0x81, carry=0.
REQ-029 incrEn rd=6 with alu_we=1, alu_wa=6, alu_wd=0x33 in the same cycle, R6=0x10 -> R6=0x11 (op wins); with alu_wa=7 -> R6=0x11 and R7=0x33.
REQ-030 funcEn func=3 -> done=1 and held through 10 no-op cycles; reset pulse -> done=0, all registers 0, take=0.
